// File: rtl/cdc_toggle_rx_multi_if.sv
// Bundle of per-channel toggle-handshake signals plus the merged valid/ready output stream.
// master: the receiver. slave: the sources/consumer side.
interface cdc_toggle_rx_multi_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_CHANNELS = 4
);
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0]            async_req_toggle;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] async_data;
    logic [NUM_CHANNELS-1:0]            ack_toggle;
    logic [DATA_WIDTH-1:0]              dst_data;
    logic [CH_W-1:0]                    dst_chan_id;
    logic                               dst_valid;
    logic                               dst_ready;
    logic [NUM_CHANNELS-1:0]            pending;
    logic [NUM_CHANNELS-1:0]            overrun_err;
    logic [NUM_CHANNELS-1:0]            err_clear;

    modport master (
        input  async_req_toggle, async_data, dst_ready, err_clear,
        output ack_toggle, dst_data, dst_chan_id, dst_valid, pending, overrun_err
    );

    modport slave (
        output async_req_toggle, async_data, dst_ready, err_clear,
        input  ack_toggle, dst_data, dst_chan_id, dst_valid, pending, overrun_err
    );
endinterface

// File: rtl/cdc_toggle_rx_multi.sv
// Multi-channel toggle-handshake CDC receiver: synchronises each request toggle, buffers
// pending requests, arbitrates them round-robin into one registered valid/ready stream and
// returns a per-channel acknowledge toggle.
module cdc_toggle_rx_multi #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input logic                   dst_clk,
    input logic                   dst_rst_n,
    cdc_toggle_rx_multi_if.master bus
);
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CHANNELS-1:0] prev_q;
    logic [NUM_CHANNELS-1:0] req_event;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [NUM_CHANNELS-1:0] overrun_q, overrun_d;
    logic [NUM_CHANNELS-1:0] ack_q, ack_d;
    logic [NUM_CHANNELS-1:0] gnt_oh;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CH_W-1:0]         chan_q, chan_d;
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                    valid_q, valid_d;
    logic                    grant_en;
    logic                    gnt_found;
    logic [CH_W-1:0]         gnt_idx;
    logic [CH_W-1:0]         scan_idx;

    // Toggle synchroniser chains; prev_q tracks the last synchronised level for edge detection.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= bus.async_req_toggle;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign req_event = sync_q[SYNC_STAGES-1] ^ prev_q;

    // The slot can take a new word when empty or when its current word leaves this cycle.
    assign grant_en = !valid_q || bus.dst_ready;

    // Round-robin search starting at rr_ptr_q; first pending channel wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        gnt_oh    = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            scan_idx = CH_W'((32'(rr_ptr_q) + k) % NUM_CHANNELS);
            if (!gnt_found && pending_q[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
        if (grant_en && gnt_found) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    // Next state for pending/overrun/ack and the output slot.
    always_comb begin
        // A request landing on the granted channel re-arms it without counting as overrun.
        pending_d = (pending_q & ~gnt_oh) | req_event;
        // Set has priority over a coincident clear.
        overrun_d = (overrun_q & ~bus.err_clear) | (req_event & pending_q & ~gnt_oh);
        ack_d     = ack_q ^ gnt_oh;
        valid_d   = valid_q;
        data_d    = data_q;
        chan_d    = chan_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant_en && gnt_found) begin
            valid_d  = 1'b1;
            data_d   = bus.async_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            chan_d   = gnt_idx;
            rr_ptr_d = CH_W'((32'(gnt_idx) + 1) % NUM_CHANNELS);
        end else if (valid_q && bus.dst_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            pending_q <= '0;
            overrun_q <= '0;
            ack_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            chan_q    <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign bus.ack_toggle  = ack_q;
    assign bus.dst_data    = data_q;
    assign bus.dst_chan_id = chan_q;
    assign bus.dst_valid   = valid_q;
    assign bus.pending     = pending_q;
    assign bus.overrun_err = overrun_q;
endmodule

// File: doc/cdc_toggle_rx_multi.md
Name: cdc_toggle_rx_multi

Overview:
Destination-side receiver for up to NUM_CHANNELS independent toggle-handshake CDC sources, all clocked by dst_clk. Each channel's request toggle is synchronised and edge-detected. Pending channels are arbitrated round-robin into a single registered valid/ready stream, and a per-channel acknowledge toggle goes back to each source. Adds channel multiplexing, buffering of pending requests, fairness and protocol-violation detection.

Parameters:
DATA_WIDTH, 32, payload width per channel
NUM_CHANNELS, 4, number of source channels (>=1)
SYNC_STAGES, 2, flops in each toggle synchroniser chain (>=2)
CH_W, (NUM_CHANNELS>1 ? $clog2(NUM_CHANNELS) : 1), channel-id width (derived, localparam)

Ports:
dst_clk  input  1  destination clock; the only clock
dst_rst_n  input  1  asynchronous, active-low reset
async_req_toggle  input  NUM_CHANNELS  per-channel request toggle from source domains; asynchronous
async_data  input  NUM_CHANNELS*DATA_WIDTH  per-channel payload; channel i at [i*DATA_WIDTH +: DATA_WIDTH]; source holds it stable from toggle until ack
ack_toggle  output  NUM_CHANNELS  per-channel acknowledge toggle back to sources (registered)
dst_data  output  DATA_WIDTH  captured payload
dst_chan_id  output  CH_W  channel index of dst_data
dst_valid  output  1  output holds a word
dst_ready  input  1  consumer accepts the word when dst_valid && dst_ready
pending  output  NUM_CHANNELS  channel has a detected request not yet granted
overrun_err  output  NUM_CHANNELS  sticky protocol-violation flag per channel
err_clear  input  NUM_CHANNELS  one-cycle pulse clears the matching overrun_err bit

Behaviour:
- Reset (async assert, sync release): all sync flops, prev-toggle regs, pending, ack_toggle, overrun_err, dst_valid, dst_data, dst_chan_id, rr_ptr = 0.
- Per channel i: SYNC_STAGES-flop chain on async_req_toggle[i]. event[i] = sync_out[i] != prev[i]. On event, prev[i] <= sync_out[i] and pending[i] <= 1 on the next edge.
- Overrun: an event while pending[i] is already 1 sets overrun_err[i]. Pending stays 1, and the two requests merge into one transfer and one ack. If err_clear[i] and a set condition occur in the same cycle, set wins.
- Output slot: one register stage. A grant is allowed when !dst_valid, or when dst_valid && dst_ready in the same cycle (back-to-back, no bubble).
- Arbitration: round-robin over pending. Search starts at rr_ptr and wraps modulo NUM_CHANNELS; the first pending channel wins.
- On grant of channel g, on the next edge:
  - dst_data <= async_data slice g; dst_chan_id <= g; dst_valid <= 1
  - pending[g] <= 0; ack_toggle[g] <= ~ack_toggle[g]
  - rr_ptr <= (g+1) mod NUM_CHANNELS
- An event arriving on channel g in the same cycle it is granted sets pending[g] again and is not flagged as overrun.
- No grant available: if dst_valid && dst_ready then dst_valid <= 0. Otherwise dst_valid, dst_data and dst_chan_id hold unchanged; they are stable under backpressure.
- Latency: toggle change before edge 1, idle and no competition → pending high after edge SYNC_STAGES+1, dst_valid high after edge SYNC_STAGES+2. ack_toggle flips on the same edge that dst_valid rises.
- Throughput: one word per cycle when all channels are pending and dst_ready is held high.
- NUM_CHANNELS=1: dst_chan_id tied to 0, rr_ptr unused.
- Reset mid-operation: any pending or in-output word is discarded and ack state returns to 0. Sources must reset their toggle to 0 as well. A source toggle left at 1 after reset is detected as a new request.
- No combinational path from async inputs to any output.

Test Plan:
- Single transfer, SYNC_STAGES=2: toggle ch1 with data 0xDEADBEEF, dst_ready=1 → dst_valid after edge 4, dst_chan_id=1, dst_data=0xDEADBEEF, ack_toggle[1] 0→1 on the same edge, dst_valid low the next cycle.
- Simultaneous requests: toggle ch0..ch3 in the same cycle with data 0xA0..0xA3, dst_ready=1 → four consecutive valid cycles with ids 0,1,2,3, no gaps, each ack flips once.
- Round-robin fairness: rr_ptr=2 after a ch1 grant; then ch0 and ch3 pend together → ch3 granted first, then ch0.
- Backpressure: dst_ready=0 for 10 cycles with ch2 word 0x12345678 valid and ch0 pending → dst_data and dst_chan_id stable, ch0 remains pending. Raise dst_ready → ch2 accepted, ch0 presented the next cycle.
- Overrun: toggle ch3 twice with dst_ready=0 → overrun_err[3]=1, exactly one ch3 word and one ack flip. err_clear[3] pulse clears it. Clear coincident with a new overrun → bit stays 1.
- Reset mid-operation: assert dst_rst_n low with dst_valid=1 and pending=4'b0110 → all outputs 0 immediately, asynchronously. After release with all source toggles 0 → no spurious dst_valid.
